// File: rtl/flr_request_scheduler.sv
// FLR request scheduler: serialises VF/PF FLR events into
// port-reset requests and returns matching completion pulses.
module flr_request_scheduler #(
    parameter int VF_NUM_W       = 11,
    parameter int PF_NUM_W       = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_MIN       = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk_2x,
    input  logic                         rst_n_2x,
    input  logic                         i_flr_rcvd_vf,
    input  logic [VF_NUM_W-1:0]          i_flr_rcvd_vf_num,
    input  logic [PF_NUM_W-1:0]          i_flr_rcvd_pf_num,
    input  logic                         i_flr_active_pf,
    input  logic                         i_port_reset_done,
    output logic                         o_port_reset_req,
    output logic                         o_flr_completed_vf,
    output logic [VF_NUM_W-1:0]          o_flr_completed_vf_num,
    output logic [PF_NUM_W-1:0]          o_flr_completed_pf_num,
    output logic                         o_flr_completed_pf,
    output logic                         o_busy,
    output logic [$clog2(FIFO_DEPTH):0]  o_pending_cnt,
    output logic                         o_overflow_err,
    output logic                         o_timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_MIN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MIN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        ASSERT    = 5'b00010,
        WAIT_DONE = 5'b00100,
        COMPLETE  = 5'b01000,
        RELEASE   = 5'b10000
    } state_t;

    state_t state, state_nxt;

    logic [VF_NUM_W-1:0] mem_vf [FIFO_DEPTH];
    logic [PF_NUM_W-1:0] mem_pf [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, off;
    logic [CW-1:0]       count;
    logic [HW-1:0]       hold_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic [VF_NUM_W-1:0] srv_vf;
    logic [PF_NUM_W-1:0] srv_pf;
    logic                srv_is_pf;
    logic                pf_pending, pf_prev;
    logic [PF_NUM_W-1:0] pf_num_pend;
    logic                pop, take_pf, tmo_hit;
    logic                dup_hit, push_ok, overflow;
    logic                pf_in_srv, pf_rise, done_nxt;

    assign pf_in_srv = (state != IDLE) && srv_is_pf;
    assign pf_rise   = i_flr_active_pf && !pf_prev;
    assign done_nxt  = (state_nxt == COMPLETE);
    assign o_busy    = (state != IDLE) || (count != '0) || pf_pending;
    assign o_pending_cnt = count;

    // Next-state decode; PF pending wins over queued VFs
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        take_pf   = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pf_pending) begin
                    take_pf   = 1'b1;
                    state_nxt = ASSERT;
                end else if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (hold_cnt == HOLD_LAST) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_port_reset_done) begin
                    state_nxt = COMPLETE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: state_nxt = RELEASE;
            RELEASE: begin
                if (!i_port_reset_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Drop a VF already queued or in service; only a real push can overflow
    always_comb begin
        dup_hit = 1'b0;
        off     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if (({1'b0, off} < count) && (mem_vf[i] == i_flr_rcvd_vf_num))
                dup_hit = 1'b1;
        end
        if (pf_in_srv == 1'b0 && state != IDLE && srv_vf == i_flr_rcvd_vf_num)
            dup_hit = 1'b1;
        push_ok  = i_flr_rcvd_vf && !dup_hit && ((count != FULL_CNT) || pop);
        overflow = i_flr_rcvd_vf && !dup_hit && (count == FULL_CNT) && !pop;
    end

    // FSM state register
    always_ff @(posedge clk_2x or negedge rst_n_2x) begin
        if (!rst_n_2x) state <= IDLE;
        else           state <= state_nxt;
    end

    // FIFO storage; validity is tracked by the pointers and count
    always_ff @(posedge clk_2x) begin
        if (push_ok) begin
            mem_vf[wr_ptr] <= i_flr_rcvd_vf_num;
            mem_pf[wr_ptr] <= i_flr_rcvd_pf_num;
        end
    end

    // Pointers, counters, in-service register and PF capture
    always_ff @(posedge clk_2x or negedge rst_n_2x) begin
        if (!rst_n_2x) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            srv_vf      <= '0;
            srv_pf      <= '0;
            srv_is_pf   <= 1'b0;
            pf_pending  <= 1'b0;
            pf_prev     <= 1'b0;
            pf_num_pend <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count   <= count + CW'(push_ok) - CW'(pop);
            pf_prev <= i_flr_active_pf;
            if (state == IDLE) hold_cnt <= '0;
            else if (state == ASSERT && hold_cnt != '1) hold_cnt <= hold_cnt + HW'(1);
            if (state == ASSERT) tmo_cnt <= '0;
            else if (state == WAIT_DONE && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            if (take_pf) begin
                srv_is_pf <= 1'b1;
                srv_vf    <= '0;
                srv_pf    <= pf_num_pend;
            end else if (pop) begin
                srv_is_pf <= 1'b0;
                srv_vf    <= mem_vf[rd_ptr];
                srv_pf    <= mem_pf[rd_ptr];
            end
            if (state == COMPLETE && srv_is_pf) begin
                pf_pending <= 1'b0;
            end else if (pf_rise && !pf_in_srv && !pf_pending) begin
                pf_pending  <= 1'b1;
                pf_num_pend <= i_flr_rcvd_pf_num;
            end
        end
    end

    // Registered outputs, driven from the decisions taken this cycle
    always_ff @(posedge clk_2x or negedge rst_n_2x) begin
        if (!rst_n_2x) begin
            o_port_reset_req       <= 1'b0;
            o_flr_completed_vf     <= 1'b0;
            o_flr_completed_pf     <= 1'b0;
            o_flr_completed_vf_num <= '0;
            o_flr_completed_pf_num <= '0;
            o_overflow_err         <= 1'b0;
            o_timeout_err          <= 1'b0;
        end else begin
            o_port_reset_req       <= (state_nxt == ASSERT) ||
                                      (state_nxt == WAIT_DONE) ||
                                      (state_nxt == COMPLETE);
            o_flr_completed_vf     <= done_nxt && !srv_is_pf;
            o_flr_completed_pf     <= done_nxt && srv_is_pf;
            o_flr_completed_vf_num <= done_nxt ? srv_vf : '0;
            o_flr_completed_pf_num <= done_nxt ? srv_pf : '0;
            o_overflow_err         <= overflow;
            o_timeout_err          <= tmo_hit;
        end
    end

endmodule

// File: tb/tb_flr_request_scheduler.sv
// Directed bench for flr_request_scheduler: vector table
// plus hand sequences for timeout and asynchronous reset.
module tb_flr_request_scheduler;

    localparam int VW = 11;
    localparam int PW = 3;
    localparam int D  = 4;
    localparam int H  = 8;
    localparam int T  = 40;

    logic          clk_2x = 1'b0;
    logic          rst_n_2x;
    logic          vf_in;
    logic [VW-1:0] vf_num_in;
    logic [PW-1:0] pf_num_in;
    logic          pf_act;
    logic          done_in;
    logic          req;
    logic          cvf;
    logic [VW-1:0] cvf_num;
    logic [PW-1:0] cpf_num;
    logic          cpf;
    logic          busy;
    logic [$clog2(D):0] cnt;
    logic          ovf;
    logic          tmo;

    int checks = 0;
    int errors = 0;

    flr_request_scheduler #(
        .VF_NUM_W(VW), .PF_NUM_W(PW), .FIFO_DEPTH(D),
        .HOLD_MIN(H), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_2x                 (clk_2x),
        .rst_n_2x               (rst_n_2x),
        .i_flr_rcvd_vf          (vf_in),
        .i_flr_rcvd_vf_num      (vf_num_in),
        .i_flr_rcvd_pf_num      (pf_num_in),
        .i_flr_active_pf        (pf_act),
        .i_port_reset_done      (done_in),
        .o_port_reset_req       (req),
        .o_flr_completed_vf     (cvf),
        .o_flr_completed_vf_num (cvf_num),
        .o_flr_completed_pf_num (cpf_num),
        .o_flr_completed_pf     (cpf),
        .o_busy                 (busy),
        .o_pending_cnt          (cnt),
        .o_overflow_err         (ovf),
        .o_timeout_err          (tmo)
    );

    always #5 clk_2x = ~clk_2x;

    typedef struct {
        logic push; int vf; int pf; logic pfa; logic done; int n;
        logic req; int cnt; logic cvf; int cnum; logic cpf; int pnum;
        logic busy; logic ovf; logic tmo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(logic push, int vf, int pf, logic pfa, logic done,
                                int n, logic rq, int c, logic cv, int cn,
                                logic cp, int pn, logic b, logic ov, logic tm);
        vec_t v;
        v.push = push; v.vf = vf; v.pf = pf; v.pfa = pfa; v.done = done; v.n = n;
        v.req = rq; v.cnt = c; v.cvf = cv; v.cnum = cn; v.cpf = cp; v.pnum = pn;
        v.busy = b; v.ovf = ov; v.tmo = tm;
        tbl.push_back(v);
    endfunction

    function automatic void row(logic push, int vf, int pf, logic pfa, logic done,
                                int n, logic rq, int c, logic b, logic ov);
        add(push, vf, pf, pfa, done, n, rq, c, 1'b0, 0, 1'b0, 0, b, ov, 1'b0);
    endfunction

    // WAIT_DONE -> COMPLETE -> RELEASE -> IDLE
    function automatic void tail(int num, int pn, logic is_pf, int c, logic b_end);
        add(0, 0, 0, 0, 1, 1, 1, c, !is_pf, is_pf ? 0 : num, is_pf, pn, 1, 0, 0);
        row(0, 0, 0, 0, 1, 1, 0, c, 1, 0);
        row(0, 0, 0, 0, 0, 1, 0, c, b_end, 0);
    endfunction

    // IDLE selection, full hold, then tail
    function automatic void service(int num, int pn, logic is_pf, int c, logic b_end);
        row(0, 0, 0, 0, 0, 1, 1, c, 1, 0);
        row(0, 0, 0, 0, 0, H, 1, c, 1, 0);
        tail(num, pn, is_pf, c, b_end);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic drop;
        logic seen;

        // single VF, done arrives after extra WAIT_DONE cycles
        row(1, 5, 0, 0, 0, 1, 0, 1, 1, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, H, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, 5, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0, 1, 5, 0, 0, 1, 0, 0);
        row(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        row(0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // fill FIFO to full, one overflow, drain in order
        row(1, 1, 1, 0, 0, 1, 0, 1, 1, 0);
        row(1, 2, 2, 0, 0, 1, 1, 1, 1, 0);
        row(1, 3, 3, 0, 0, 1, 1, 2, 1, 0);
        row(1, 4, 4, 0, 0, 1, 1, 3, 1, 0);
        row(1, 5, 5, 0, 0, 1, 1, 4, 1, 0);
        row(1, 6, 6, 0, 0, 1, 1, 4, 1, 1);
        row(0, 0, 0, 0, 0, 1, 1, 4, 1, 0);
        row(0, 0, 0, 0, 0, 3, 1, 4, 1, 0);
        tail(1, 1, 0, 4, 1);
        service(2, 2, 0, 3, 1);
        service(3, 3, 0, 2, 1);
        service(4, 4, 0, 1, 1);
        service(5, 5, 0, 0, 0);
        // PF rises while VF3 in service and VF7 queued
        row(1, 3, 1, 0, 0, 1, 0, 1, 1, 0);
        row(1, 7, 2, 0, 0, 1, 1, 1, 1, 0);
        row(0, 0, 0, 1, 0, 1, 1, 1, 1, 0);
        row(0, 0, 0, 0, 0, H - 1, 1, 1, 1, 0);
        tail(3, 1, 0, 1, 1);
        service(0, 0, 1, 1, 1);
        service(7, 2, 0, 0, 0);
        // duplicates against in-service VF and against a queued entry
        row(1, 2, 3, 0, 0, 1, 0, 1, 1, 0);
        row(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        row(1, 2, 3, 0, 0, 1, 1, 0, 1, 0);
        row(1, 9, 4, 0, 0, 1, 1, 1, 1, 0);
        row(1, 9, 4, 0, 0, 1, 1, 1, 1, 0);
        row(0, 0, 0, 0, 0, H - 3, 1, 1, 1, 0);
        tail(2, 3, 0, 1, 1);
        service(9, 4, 0, 0, 0);
        row(0, 0, 0, 0, 0, 20, 0, 0, 0, 0);

        rst_n_2x  = 1'b0;
        vf_in     = 1'b0;
        vf_num_in = '0;
        pf_num_in = '0;
        pf_act    = 1'b0;
        done_in   = 1'b0;
        repeat (3) @(posedge clk_2x);
        #1;
        chk("rst req", req, 0);
        chk("rst cnt", cnt, 0);
        chk("rst busy", busy, 0);
        chk("rst cvf", cvf, 0);
        chk("rst cpf", cpf, 0);
        chk("rst cnum", cvf_num, 0);
        chk("rst pnum", cpf_num, 0);
        chk("rst ovf", ovf, 0);
        chk("rst tmo", tmo, 0);
        @(negedge clk_2x);
        rst_n_2x = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk_2x);
            vf_in     = tbl[k].push;
            vf_num_in = VW'(tbl[k].vf);
            pf_num_in = PW'(tbl[k].pf);
            pf_act    = tbl[k].pfa;
            done_in   = tbl[k].done;
            repeat (tbl[k].n) @(posedge clk_2x);
            #1;
            chk($sformatf("row%0d req", k), req, tbl[k].req);
            chk($sformatf("row%0d cnt", k), cnt, tbl[k].cnt);
            chk($sformatf("row%0d cvf", k), cvf, tbl[k].cvf);
            chk($sformatf("row%0d cnum", k), cvf_num, tbl[k].cnum);
            chk($sformatf("row%0d cpf", k), cpf, tbl[k].cpf);
            chk($sformatf("row%0d pnum", k), cpf_num, tbl[k].pnum);
            chk($sformatf("row%0d busy", k), busy, tbl[k].busy);
            chk($sformatf("row%0d ovf", k), ovf, tbl[k].ovf);
            chk($sformatf("row%0d tmo", k), tmo, tbl[k].tmo);
        end

        // timeout: done never arrives
        @(negedge clk_2x);
        vf_in = 1'b0; pf_act = 1'b0; done_in = 1'b0;
        @(negedge clk_2x);
        vf_in = 1'b1; vf_num_in = 11'd11; pf_num_in = 3'd4;
        @(negedge clk_2x);
        vf_in = 1'b0;
        @(posedge clk_2x);
        #1;
        chk("tmo req rise", req, 1);
        cyc  = 0;
        drop = 1'b0;
        while (!tmo && cyc < H + T + 20) begin
            @(posedge clk_2x);
            #1;
            cyc++;
            if (!req) drop = 1'b1;
        end
        chk("tmo latency", cyc, H + T);
        chk("tmo req held", drop, 0);
        chk("tmo cvf", cvf, 1);
        chk("tmo cnum", cvf_num, 11);
        chk("tmo pnum", cpf_num, 4);
        @(posedge clk_2x);
        #1;
        chk("tmo pulse width", tmo, 0);
        chk("tmo req release", req, 0);
        @(posedge clk_2x);
        #1;
        chk("tmo idle busy", busy, 0);

        // asynchronous reset while in WAIT_DONE
        @(negedge clk_2x);
        vf_in = 1'b1; vf_num_in = 11'd12; pf_num_in = 3'd5;
        @(negedge clk_2x);
        vf_num_in = 11'd13; pf_num_in = 3'd6;
        @(negedge clk_2x);
        vf_in = 1'b0;
        repeat (H + 3) @(posedge clk_2x);
        #1;
        chk("arst pre req", req, 1);
        chk("arst pre cnt", cnt, 1);
        #1;
        rst_n_2x = 1'b0;
        #1;
        chk("arst req", req, 0);
        chk("arst cnt", cnt, 0);
        chk("arst busy", busy, 0);
        @(negedge clk_2x);
        rst_n_2x = 1'b1;
        done_in  = 1'b1;
        seen     = 1'b0;
        repeat (6) begin
            @(posedge clk_2x);
            #1;
            if (cvf || cpf || req) seen = 1'b1;
        end
        chk("arst no completion", seen, 0);
        chk("arst idle busy", busy, 0);
        done_in = 1'b0;
        @(negedge clk_2x);
        vf_in = 1'b1; vf_num_in = 11'd14; pf_num_in = 3'd1; done_in = 1'b1;
        @(negedge clk_2x);
        vf_in = 1'b0;
        cyc = 0;
        while (!cvf && cyc < 3 * H) begin
            @(posedge clk_2x);
            #1;
            cyc++;
        end
        chk("post rst cvf", cvf, 1);
        chk("post rst cnum", cvf_num, 14);
        chk("post rst pnum", cpf_num, 1);
        @(negedge clk_2x);
        done_in = 1'b0;
        repeat (3) @(posedge clk_2x);
        #1;
        chk("post rst busy", busy, 0);
        chk("post rst req", req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
